threewire_master_arbiter: RTL

- Shares one threewire_master_ctrl instance between TWA_NUM_REQ requesters.
- Selects one pending requester and latches its command (mode, address, write data).
- Holds the latched command stable on the master inputs for the whole transfer, because the master samples them throughout the operation.
- Issues the single-cycle start pulse, tracks the master's in-progress flag, and returns read data and a completion pulse to the winning requester.

---
 rtl/twa_pkg.sv | 21 ++
 rtl/threewire_req_picker.sv | 49 ++++
 rtl/threewire_master_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/twa_pkg.sv
// Shared types and helpers for the three-wire master arbiter.
package twa_pkg;

    // Arbiter FSM states, stored in a 3-bit register.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        COMPLETE  = 3'd4
    } twa_state_e;

    // Ceiling log2 with a floor of 1, so a single requester still gets a 1-bit id.
    function automatic int twa_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/threewire_req_picker.sv
// Combinational requester selection.
// Build option TWA_ROUND_ROBIN_EN: rotating priority starting after ptr;
// otherwise fixed priority with the lowest index winning (ptr ignored).
module threewire_req_picker
    import twa_pkg::*;
#(
    parameter int N = 4,
    parameter int W = twa_clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         found
);

`ifdef TWA_ROUND_ROBIN_EN
    int idx;

    // Scan N slots starting one past the last winner; first valid slot wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                winner = W'(idx);
                found  = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Walk from the top down so the lowest set index is the last one written.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[k]) begin
                winner = W'(k);
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/threewire_master_arbiter.sv
// Shares one three-wire master between TWA_NUM_REQ requesters: picks a
// winner, latches its command, pulses start, follows the master's
// in-progress flag and returns read data plus a done pulse.
// Build option TWA_ROUND_ROBIN_EN selects rotating priority (see picker).
module threewire_master_arbiter
    import twa_pkg::*;
#(
    parameter int TWA_NUM_REQ      = 4,
    parameter int TWA_ADDRESS_BITS = 10,
    parameter int TWA_DATA_BITS    = 32,
    localparam int GW = twa_clog2(TWA_NUM_REQ)
) (
    input  logic                                  in_clk,
    input  logic                                  in_rst,
    input  logic [TWA_NUM_REQ-1:0]                in_req_valid,
    input  logic [TWA_NUM_REQ-1:0]                in_req_mode_wr,
    input  logic [TWA_NUM_REQ*TWA_ADDRESS_BITS-1:0] in_req_addr,
    input  logic [TWA_NUM_REQ*TWA_DATA_BITS-1:0]  in_req_wr_data,
    output logic [TWA_NUM_REQ-1:0]                out_req_ack,
    output logic [TWA_NUM_REQ-1:0]                out_req_done,
    output logic [TWA_DATA_BITS-1:0]              out_rd_data,
    output logic [GW-1:0]                         out_grant_id,
    output logic                                  out_busy,
    output logic                                  out_twm_start,
    output logic                                  out_twm_mode_wr,
    output logic [TWA_ADDRESS_BITS-1:0]           out_twm_addr,
    output logic [TWA_DATA_BITS-1:0]              out_twm_wr_data,
    input  logic [TWA_DATA_BITS-1:0]              in_twm_rd_data,
    input  logic                                  in_twm_in_progress
);

    twa_state_e    state, state_next;
    logic [GW-1:0] ptr;
    logic [GW-1:0] pick_w;
    logic          pick_found;
    logic          grant_now;

    threewire_req_picker #(.N(TWA_NUM_REQ), .W(GW)) u_picker (
        .valid  (in_req_valid),
        .ptr    (ptr),
        .winner (pick_w),
        .found  (pick_found)
    );

    assign grant_now = (state == IDLE) && pick_found;
    assign out_busy  = (state != IDLE);

`ifdef TWA_ROUND_ROBIN_EN
    // Last-winner pointer; reset to N-1 so requester 0 is searched first.
    always_ff @(posedge in_clk) begin
        if (in_rst)         ptr <= GW'(TWA_NUM_REQ - 1);
        else if (grant_now) ptr <= pick_w;
    end
`else
    assign ptr = '0;
`endif

    // State register.
    always_ff @(posedge in_clk) begin
        if (in_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pick_found)          state_next = ISSUE;
            ISSUE:                              state_next = WAIT_BUSY;
            WAIT_BUSY: if (in_twm_in_progress)  state_next = WAIT_DONE;
            WAIT_DONE: if (!in_twm_in_progress) state_next = COMPLETE;
            COMPLETE:                           state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Registered outputs: command latch and start/ack on grant, read-data
    // capture and done when the master drops in-progress.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_req_ack     <= '0;
            out_req_done    <= '0;
            out_rd_data     <= '0;
            out_grant_id    <= '0;
            out_twm_start   <= 1'b0;
            out_twm_mode_wr <= 1'b0;
            out_twm_addr    <= '0;
            out_twm_wr_data <= '0;
        end else begin
            out_twm_start <= 1'b0;
            out_req_ack   <= '0;
            out_req_done  <= '0;
            if (grant_now) begin
                out_grant_id    <= pick_w;
                out_twm_mode_wr <= in_req_mode_wr[pick_w];
                out_twm_addr    <= in_req_addr[pick_w*TWA_ADDRESS_BITS +: TWA_ADDRESS_BITS];
                out_twm_wr_data <= in_req_wr_data[pick_w*TWA_DATA_BITS +: TWA_DATA_BITS];
                out_twm_start   <= 1'b1;
                out_req_ack     <= TWA_NUM_REQ'(1) << pick_w;
            end
            if (state == WAIT_DONE && !in_twm_in_progress) begin
                if (!out_twm_mode_wr) out_rd_data <= in_twm_rd_data;
                out_req_done <= TWA_NUM_REQ'(1) << out_grant_id;
            end
        end
    end

endmodule
